hilo_retire: RTL and testbench
==============================

HILO_RETIRE -- requirements
Module: hilo_retire

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, meaning the number of outstanding HI/LO write entries; the value SHALL be a power of two, 2..16.
REQ-002 The module SHALL have parameter DW, default 32, meaning the HI/LO data width.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port alloc_vld, input, 1: issue of a HI/LO-writing instruction, the same event that drives the allocation side of the LO outstanding-write tracker.
REQ-006 Port alloc_hi, input, 1: the allocating instruction writes HI.
REQ-007 Port alloc_lo, input, 1: the allocating instruction writes LO.
REQ-008 Port alloc_rdy, output, 1: queue not full.
REQ-009 Port res_vld, input, 1: in-order result from the mult/div/mt unit.
REQ-010 Port res_hi, input, DW: HI result.
REQ-011 Port res_lo, input, DW: LO result.
REQ-012 Port hi_o, output, DW: architectural HI.
REQ-013 Port lo_o, output, DW: architectural LO.
REQ-014 Port ret_hi, output, 1: one-cycle HI retire pulse.
REQ-015 Port ret_lo, output, 1: one-cycle LO retire pulse; it drives wreg_wb of the LO tracker.
REQ-016 Port empty, output, 1: no entries outstanding.
REQ-017 Port err, output, 1: sticky protocol-error flag.

Function
REQ-018 The queue SHALL be a circular buffer of DEPTH entries, each holding {hi_en, lo_en}, with a write pointer, a read pointer (log2 DEPTH bits, natural wrap) and a count of 0..DEPTH.
REQ-019 An alloc SHALL be accepted when alloc_vld=1 and alloc_rdy=1; it SHALL write {alloc_hi, alloc_lo} at the write pointer and advance the pointer by one.
REQ-020 alloc_rdy SHALL equal (count != DEPTH), derived combinationally from registered count.
REQ-021 A result SHALL be accepted when res_vld=1 and count != 0 at the clock edge; an entry allocated in the same cycle SHALL NOT be consumed by that result.
REQ-022 On acceptance, hi_o SHALL load res_hi if the head hi_en=1, lo_o SHALL load res_lo if the head lo_en=1, the entry SHALL be popped and the read pointer SHALL advance.
REQ-023 ret_hi and ret_lo SHALL be registered and SHALL assert for exactly one cycle, the cycle after acceptance (the same cycle the new hi_o/lo_o is visible), gated by the head hi_en and lo_en respectively.
REQ-024 An entry with hi_en=lo_en=0 SHALL pop with no register write and no pulse.
REQ-025 Simultaneous accepted alloc and result SHALL leave count unchanged and move both pointers.
REQ-026 At full, a result plus alloc in the same cycle SHALL accept only the result, because alloc_rdy is 0 that cycle.
REQ-027 err SHALL set and hold until reset when alloc_vld=1 and alloc_rdy=0 (overflow; the alloc is dropped).
REQ-028 err SHALL also set and hold until reset when res_vld=1 and count=0 (underflow; the result is dropped and hi_o/lo_o are unchanged).
REQ-029 Back-to-back results SHALL retire one per cycle; latency from res_vld to ret_* and register update SHALL be 1 cycle.
REQ-030 empty SHALL equal (count == 0).

Reset
REQ-031 While rst_n=0, asynchronously: pointers=0, count=0, all entry bits=0, hi_o=0, lo_o=0, ret_hi=0, ret_lo=0, err=0; therefore alloc_rdy=1 and empty=1.
REQ-032 An assertion of rst_n during operation SHALL discard all outstanding entries with no retire pulse; after release, the first alloc SHALL use entry 0.

Verification
REQ-033 Scenario: alloc {hi=1,lo=1}, then next cycle res_vld with hi=0x11, lo=0x22 -> next cycle hi_o=0x11, lo_o=0x22, ret_hi=ret_lo=1 for one cycle, empty=1.
REQ-034 Scenario: 4 allocs {0,1}, a 5th alloc -> alloc_rdy=0 after the 4th, err=1, and 4 results then give exactly 4 ret_lo pulses with hi_o unchanged at 0.
REQ-035 Scenario: res_vld with empty queue -> err=1, hi_o/lo_o stay 0, no pulse.
REQ-036 Scenario: with count=1, alloc and res_vld in the same cycle -> count stays 1, one retire pulse, and the new entry retires on the next result.
REQ-037 Scenario: 10 alloc/result pairs of alternating {1,0}/{0,1} -> pointer wrap, and ret_hi/ret_lo alternate in order with correct data.
REQ-038 Scenario: reset pulsed with 3 entries outstanding -> all outputs return to reset values, no ret_* pulse, and the next alloc/result pair retires normally.

Source files
------------

// File: rtl/hilo_retire.sv
// In-order HI/LO retire queue: tracks outstanding HI/LO writers and commits
// mult/div/mt results into the architectural HI and LO registers.
module hilo_retire #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alloc_vld,
    input  logic          alloc_hi,
    input  logic          alloc_lo,
    output logic          alloc_rdy,
    input  logic          res_vld,
    input  logic [DW-1:0] res_hi,
    input  logic [DW-1:0] res_lo,
    output logic [DW-1:0] hi_o,
    output logic [DW-1:0] lo_o,
    output logic          ret_hi,
    output logic          ret_lo,
    output logic          empty,
    output logic          err
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] hi_en_q, hi_en_d;
    logic [DEPTH-1:0] lo_en_q, lo_en_d;
    logic [DW-1:0]    hi_q, hi_d;
    logic [DW-1:0]    lo_q, lo_d;
    logic             ret_hi_q, ret_hi_d;
    logic             ret_lo_q, ret_lo_d;
    logic             err_q, err_d;
    logic             alloc_acc, res_acc;
    logic             head_hi, head_lo;

    assign alloc_rdy = (count_q != FULL_CNT);
    assign empty     = (count_q == '0);
    assign alloc_acc = alloc_vld & alloc_rdy;
    // The head is sampled before this edge's write, so a same-cycle alloc is never consumed.
    assign res_acc   = res_vld & ~empty;
    assign head_hi   = hi_en_q[rd_ptr_q];
    assign head_lo   = lo_en_q[rd_ptr_q];

    always_comb begin
        // NOTE: every next-state variable takes its held value first, so no path infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hi_en_d  = hi_en_q;
        lo_en_d  = lo_en_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        ret_hi_d = 1'b0;
        ret_lo_d = 1'b0;
        err_d    = err_q | (alloc_vld & ~alloc_rdy) | (res_vld & empty);

        if (alloc_acc) begin
            hi_en_d[wr_ptr_q] = alloc_hi;
            lo_en_d[wr_ptr_q] = alloc_lo;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end

        if (res_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            ret_hi_d = head_hi;
            ret_lo_d = head_lo;
            if (head_hi) hi_d = res_hi;
            if (head_lo) lo_d = res_lo;
        end

        case ({alloc_acc, res_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: the entry bits are a few flops, not a RAM, so they are reset with the rest of the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hi_en_q  <= '0;
            lo_en_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            ret_hi_q <= 1'b0;
            ret_lo_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hi_en_q  <= hi_en_d;
            lo_en_q  <= lo_en_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            ret_hi_q <= ret_hi_d;
            ret_lo_q <= ret_lo_d;
            err_q    <= err_d;
        end
    end

    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
    assign ret_hi = ret_hi_q;
    assign ret_lo = ret_lo_q;
    assign err    = err_q;

endmodule

// File: tb/tb_hilo_retire.sv
// Self-checking bench for hilo_retire: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_hilo_retire;
    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic          clk;
    logic          rst_n;
    logic          alloc_vld, alloc_hi, alloc_lo;
    logic          alloc_rdy;
    logic          res_vld;
    logic [DW-1:0] res_hi, res_lo;
    logic [DW-1:0] hi_o, lo_o;
    logic          ret_hi, ret_lo;
    logic          empty, err;

    hilo_retire #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_vld(alloc_vld), .alloc_hi(alloc_hi), .alloc_lo(alloc_lo),
        .alloc_rdy(alloc_rdy),
        .res_vld(res_vld), .res_hi(res_hi), .res_lo(res_lo),
        .hi_o(hi_o), .lo_o(lo_o), .ret_hi(ret_hi), .ret_lo(ret_lo),
        .empty(empty), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int lo_pulses;
    int hi_pulses;

    // Reference model: a FIFO of {hi_en, lo_en} plus the architectural registers.
    logic [1:0]    mq[$];
    logic [DW-1:0] m_hi, m_lo;
    logic          m_rh, m_rl, m_err;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_hi = '0; m_lo = '0; m_rh = 1'b0; m_rl = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_edge();
        logic       r_ok, a_ok;
        logic [1:0] e;
        r_ok = res_vld && (mq.size() != 0);
        a_ok = alloc_vld && (mq.size() != DEPTH);
        if (alloc_vld && !a_ok) m_err = 1'b1;
        if (res_vld && mq.size() == 0) m_err = 1'b1;
        m_rh = 1'b0;
        m_rl = 1'b0;
        if (r_ok) begin
            e = mq.pop_front();
            if (e[1]) begin m_hi = res_hi; m_rh = 1'b1; end
            if (e[0]) begin m_lo = res_lo; m_rl = 1'b1; end
        end
        if (a_ok) mq.push_back({alloc_hi, alloc_lo});
    endtask

    task automatic compare_all();
        check("hi_o", hi_o, m_hi);
        check("lo_o", lo_o, m_lo);
        check("ret_hi", DW'(ret_hi), DW'(m_rh));
        check("ret_lo", DW'(ret_lo), DW'(m_rl));
        check("alloc_rdy", DW'(alloc_rdy), DW'(mq.size() != DEPTH));
        check("empty", DW'(empty), DW'(mq.size() == 0));
        check("err", DW'(err), DW'(m_err));
    endtask

    task automatic step(input logic av, input logic ah, input logic al,
                        input logic rv, input logic [DW-1:0] rh, input logic [DW-1:0] rl);
        alloc_vld = av; alloc_hi = ah; alloc_lo = al;
        res_vld = rv; res_hi = rh; res_lo = rl;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        if (ret_lo) lo_pulses++;
        if (ret_hi) hi_pulses++;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        alloc_vld = 1'b0; alloc_hi = 1'b0; alloc_lo = 1'b0;
        res_vld = 1'b0; res_hi = '0; res_lo = '0;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        alloc_vld = 1'b0; alloc_hi = 1'b0; alloc_lo = 1'b0;
        res_vld = 1'b0; res_hi = '0; res_lo = '0;
        model_reset();
        #2;
        do_reset();

        // Single HI+LO writer.
        step(1'b1, 1'b1, 1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h11, 32'h22);
        check("s1_hi", hi_o, 32'h11);
        check("s1_lo", lo_o, 32'h22);
        check("s1_ret", DW'({ret_hi, ret_lo}), 32'h3);
        check("s1_empty", DW'(empty), 32'h1);
        idle();
        check("s1_ret_drop", DW'({ret_hi, ret_lo}), 32'h0);

        // Fill, overflow, then drain LO-only entries.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, '0, '0);
        check("s2_full_rdy", DW'(alloc_rdy), 32'h0);
        step(1'b1, 1'b0, 1'b1, 1'b0, '0, '0);
        check("s2_err", DW'(err), 32'h1);
        lo_pulses = 0;
        hi_pulses = 0;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, $urandom, 32'h100 + 32'(i));
        idle();
        check("s2_lo_pulses", DW'(lo_pulses), 32'd4);
        check("s2_hi_pulses", DW'(hi_pulses), 32'd0);
        check("s2_hi_zero", hi_o, 32'h0);
        check("s2_lo_last", lo_o, 32'h103);

        // Underflow.
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'hdead, 32'hbeef);
        check("s3_err", DW'(err), 32'h1);
        check("s3_hi", hi_o, 32'h0);
        check("s3_ret", DW'({ret_hi, ret_lo}), 32'h0);

        // Alloc and result together at count=1; full plus result accepts only the result.
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'haa, 32'hbb);
        check("s4_ret", DW'({ret_hi, ret_lo}), 32'h2);
        check("s4_empty", DW'(empty), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'hcc, 32'hdd);
        check("s4_second", DW'({ret_hi, ret_lo}), 32'h1);
        check("s4_lo", lo_o, 32'hdd);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0, '0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h5, 32'h6);
        check("s4_full_res", DW'(alloc_rdy), 32'h1);
        idle();

        // Alternating writers across pointer wrap; also a no-write entry.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, (i % 2) == 0, (i % 2) == 1, 1'b0, '0, '0);
            step(1'b0, 1'b0, 1'b0, 1'b1, 32'h1000 + 32'(i), 32'h2000 + 32'(i));
            check("s5_alt", DW'({ret_hi, ret_lo}), ((i % 2) == 0) ? 32'h2 : 32'h1);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h77, 32'h88);
        check("s5_nowrite", DW'({ret_hi, ret_lo}), 32'h0);

        // Reset with entries outstanding.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, '0, '0);
        do_reset();
        check("s6_rdy", DW'(alloc_rdy), 32'h1);
        idle();
        check("s6_no_pulse", DW'({ret_hi, ret_lo}), 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h3c, 32'h4d);
        check("s6_hi", hi_o, 32'h3c);

        // Random traffic with periodic resets so the sticky error stays informative.
        for (int c = 0; c < 600; c++) begin
            if (c % 60 == 0) do_reset();
            step($urandom_range(0, 99) < 55, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 99) < 45, $urandom, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
